fir_decim_buf: RTL and testbench
================================

FIR_DECIM_BUF -- requirements
Module: fir_decim_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 32, sample width matching the FIR output.
REQ-002 SHALL have parameter DECIM, default 4, decimation ratio (legal 1..16).
REQ-003 SHALL have parameter DEPTH, default 8, FIFO depth (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port x_rsc_dat  input  DATA_W  sample from the upstream fir y_rsc_dat.
REQ-007 SHALL have port x_vld  input  1  x_rsc_dat valid this cycle; no back-pressure upstream.
REQ-008 SHALL have port clr  input  1  synchronous flush.
REQ-009 SHALL have port y_rsc_dat  output  DATA_W  FIFO head sample.
REQ-010 SHALL have port y_vld  output  1  y_rsc_dat holds a valid sample.
REQ-011 SHALL have port y_rdy  input  1  consumer accepts y_rsc_dat.
REQ-012 SHALL have port level  output  clog2(DEPTH+1)  current FIFO occupancy.
REQ-013 SHALL have port ovf  output  1  sticky flag: a kept sample was dropped.

Function
REQ-014 SHALL hold a phase counter 0..DECIM-1 that advances, with wrap to 0, on every cycle with x_vld=1.
REQ-015 SHALL keep a sample only when x_vld=1 and phase=0, so the first valid sample after reset or clr is kept.
REQ-016 SHALL pass every valid sample when DECIM=1.
REQ-017 SHALL push a kept sample into the FIFO unmodified, full DATA_W, with no arithmetic.
REQ-018 SHALL present the FIFO head as first-word fall-through: y_vld = (level != 0), y_rsc_dat = oldest entry.
REQ-019 SHALL pop one entry on each cycle with y_vld=1 and y_rdy=1.
REQ-020 SHALL give a kept sample at cycle n, with the FIFO empty, y_vld=1 and that data at cycle n+1.
REQ-021 SHALL accept a push to a full FIFO when a pop occurs in the same cycle, with level unchanged and no overflow.
REQ-022 SHALL drop a kept sample when the FIFO is full and no pop occurs, set ovf=1, and still advance phase.
REQ-023 SHALL leave level unchanged on a simultaneous push and pop to a non-empty FIFO; a push to an empty FIFO with y_rdy=1 is not popped that cycle.
REQ-024 SHALL wrap the read and write pointers modulo DEPTH.
REQ-025 SHALL ignore y_rdy while y_vld=0.
REQ-026 SHALL clear ovf only by reset or clr.
REQ-027 SHALL, on clr=1, empty the FIFO, set phase=0 and ovf=0, and discard that cycle's push and pop; y_rsc_dat is don't-care.

Reset
REQ-028 SHALL, while rst=0, immediately force y_vld=0, level=0, ovf=0, y_rsc_dat=0, phase=0 and both pointers to 0.
REQ-029 SHALL lose all FIFO contents on reset asserted mid-operation; the first valid sample after release is kept.
REQ-030 SHALL leave FIFO storage RAM contents unreset; only the output must read 0 while empty after reset.

Structure
REQ-031 SHALL place DATA_W, DEPTH and the derived level width constant in shared package fir_pkg, also used by fir.
REQ-032 SHALL implement the FIFO as sub-module fir_sync_fifo (push, pop, clr, FWFT data, level, full, empty), with decimation and ovf logic in the top.

Verification
REQ-033 SHALL cover: DECIM=4, x_vld=1 with x=1..12 one per cycle, y_rdy=1 -> outputs 1, 5, 9, each one cycle after input; ovf=0.
REQ-034 SHALL cover: DECIM=1, DEPTH=8, y_rdy=0, 10 valid samples 0x10..0x19 -> level=8, ovf=1 after the 9th; then y_rdy=1 -> outputs 0x10..0x17 only.
REQ-035 SHALL cover: full FIFO, y_rdy=1 and a kept sample in the same cycle -> level stays 8, ovf stays 0, new sample appears last.
REQ-036 SHALL cover: DECIM=4, x_vld toggling 1,0,1,0 with x=1..8 -> kept samples are those at the 1st and 5th valid cycles (1 and 5).
REQ-037 SHALL cover: rst=0 for 1 cycle mid-stream with level=3 and ovf=1 -> level=0, y_vld=0, ovf=0 at once; the next valid x is output.
REQ-038 SHALL cover: clr=1 with level=5 and phase=2 -> next cycle level=0, ovf=0; the next valid sample is kept.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath and its decimating output buffer.
package fir_pkg;

    // Sample width produced by the FIR and carried through the buffer.
    localparam int unsigned FIR_DATA_W = 32;

    // Default output buffer depth (power of two, at least 2).
    localparam int unsigned FIR_DEPTH = 8;

    // Width needed to count 0..depth inclusive.
    function automatic int unsigned level_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    localparam int unsigned FIR_LEVEL_W = level_width(FIR_DEPTH);

    typedef logic [FIR_DATA_W-1:0] fir_sample_t;

endpackage

// File: rtl/fir_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. Storage is not reset; the head
// output is forced to zero whenever the FIFO is empty.
module fir_sync_fifo
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = FIR_DATA_W,
    parameter int unsigned DEPTH  = FIR_DEPTH,
    localparam int unsigned LVL_W = level_width(DEPTH),
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_dat,
    output logic [LVL_W-1:0]  level,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]  level_q;
    logic              push_en, pop_en;

    // A pop needs data present; a push to a full FIFO needs a same-cycle pop.
    always_comb begin
        pop_en  = pop & ~empty;
        push_en = push & (~full | pop_en);
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_en, pop_en})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    // Storage write; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_en && !clr) mem[wr_ptr_q] <= push_dat;
    end

    // Status flags and fall-through head.
    always_comb begin
        level   = level_q;
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        pop_dat = empty ? '0 : mem[rd_ptr_q];
    end

endmodule

// File: rtl/fir_decim_buf.sv
// Decimates the FIR output stream by DECIM and buffers kept samples in a FWFT
// FIFO. Kept samples that find the FIFO full (with no pop) are dropped and
// latch the sticky ovf flag.
module fir_decim_buf
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W = FIR_DATA_W,
    parameter int unsigned DECIM  = 4,
    parameter int unsigned DEPTH  = FIR_DEPTH,
    localparam int unsigned LVL_W = level_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x_rsc_dat,
    input  logic              x_vld,
    input  logic              clr,
    output logic [DATA_W-1:0] y_rsc_dat,
    output logic              y_vld,
    input  logic              y_rdy,
    output logic [LVL_W-1:0]  level,
    output logic              ovf
);

    localparam int unsigned PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);

    logic [PH_W-1:0] phase_q, phase_d;
    logic            ovf_q;
    logic            keep, drop;
    logic            fifo_full, fifo_empty;

    // Keep on phase 0; drop only when full and the consumer is not draining.
    always_comb begin
        keep    = x_vld && (phase_q == '0);
        drop    = keep && fifo_full && !(y_rdy && !fifo_empty);
        phase_d = phase_q;
        if (x_vld) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + 1'b1;
    end

    // Phase counter and sticky overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            phase_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            if (drop) ovf_q <= 1'b1;
        end
    end

    fir_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .push     (keep),
        .push_dat (x_rsc_dat),
        .pop      (y_rdy),
        .pop_dat  (y_rsc_dat),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Output valid mirrors non-empty FIFO.
    always_comb begin
        y_vld = !fifo_empty;
        ovf   = ovf_q;
    end

endmodule

// File: tb/tb_fir_decim_buf.sv
// Bench for fir_decim_buf: two instances (DECIM=4 and DECIM=1) share stimulus
// and are checked every cycle against a queue-style reference model.
module tb_fir_decim_buf;

    localparam int unsigned DW = 32;
    localparam int unsigned DP = 8;
    localparam int unsigned LW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] x   = '0;
    logic          xv  = 1'b0;
    logic          clr = 1'b0;
    logic          rdy = 1'b0;

    logic [DW-1:0] y_dat [2];
    logic          yv    [2];
    logic [LW-1:0] lvl   [2];
    logic          ov    [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fir_decim_buf #(.DATA_W(DW), .DECIM(4), .DEPTH(DP)) u_d4 (
        .clk(clk), .rst(rst), .x_rsc_dat(x), .x_vld(xv), .clr(clr),
        .y_rsc_dat(y_dat[0]), .y_vld(yv[0]), .y_rdy(rdy), .level(lvl[0]), .ovf(ov[0])
    );

    fir_decim_buf #(.DATA_W(DW), .DECIM(1), .DEPTH(DP)) u_d1 (
        .clk(clk), .rst(rst), .x_rsc_dat(x), .x_vld(xv), .clr(clr),
        .y_rsc_dat(y_dat[1]), .y_vld(yv[1]), .y_rdy(rdy), .level(lvl[1]), .ovf(ov[1])
    );

    // Reference model: per instance a bounded queue in a ring, a valid-sample
    // counter mod DECIM, a sticky drop flag and a log of delivered samples.
    int unsigned   dec  [2] = '{4, 1};
    logic [DW-1:0] mq   [2][DP];
    int            mhd  [2];
    int            mcnt [2];
    int            mph  [2];
    bit            movf [2];
    logic [DW-1:0] mlog [2][64];
    int            nlog [2];

    always @(posedge clk or negedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst || clr) begin
                mhd[k] = 0; mcnt[k] = 0; mph[k] = 0; movf[k] = 1'b0; nlog[k] = 0;
            end else begin
                bit do_pop, do_keep;
                do_pop  = rdy && (mcnt[k] > 0);
                do_keep = xv && (mph[k] == 0);
                if (xv) mph[k] = (mph[k] + 1) % int'(dec[k]);
                if (do_pop) begin
                    if (nlog[k] < 64) mlog[k][nlog[k]] = mq[k][mhd[k]];
                    nlog[k]++;
                    mhd[k]  = (mhd[k] + 1) % DP;
                    mcnt[k]--;
                end
                if (do_keep) begin
                    if (mcnt[k] < DP) begin
                        mq[k][(mhd[k] + mcnt[k]) % DP] = x;
                        mcnt[k]++;
                    end else begin
                        movf[k] = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("y_vld[d%0d]", dec[k]), DW'(yv[k]), DW'(mcnt[k] != 0));
            chk($sformatf("level[d%0d]", dec[k]), DW'(lvl[k]), DW'(mcnt[k]));
            chk($sformatf("ovf[d%0d]", dec[k]), DW'(ov[k]), DW'(movf[k]));
            if (mcnt[k] != 0)
                chk($sformatf("y_dat[d%0d]", dec[k]), y_dat[k], mq[k][mhd[k]]);
            else if (!rst)
                chk($sformatf("y_dat_rst[d%0d]", dec[k]), y_dat[k], '0);
        end
    end

    // One clock of stimulus; returns 1 time unit after the rising edge.
    task automatic cyc(input bit v, input logic [DW-1:0] d, input bit r, input bit c);
        xv = v; x = d; rdy = r; clr = c;
        @(posedge clk);
        #1;
        xv = 1'b0; clr = 1'b0;
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("rst_level", DW'(lvl[0]), 0);
        chk("rst_vld", DW'(yv[1]), 0);
        chk("rst_dat", y_dat[0], 0);
        rst = 1'b1;
        cyc(0, 0, 0, 0);

        // DECIM=4 streaming: kept 1, 5, 9, each visible one cycle after input
        for (int i = 1; i <= 12; i++) begin
            cyc(1, DW'(i), 1, 0);
            if (i == 1) begin
                chk("lat_vld", DW'(yv[0]), 1);
                chk("lat_dat", y_dat[0], 1);
            end
        end
        cyc(0, 0, 1, 0);
        chk("s1_n", nlog[0], 3);
        chk("s1_o0", mlog[0][0], 1);
        chk("s1_o1", mlog[0][1], 5);
        chk("s1_o2", mlog[0][2], 9);
        chk("s1_ovf", DW'(ov[0]), 0);

        // DECIM=1 overflow with consumer stalled
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(1, DW'(32'h10 + i), 0, 0);
            if (i == 7) begin
                chk("s2_lvl8", DW'(lvl[1]), 8);
                chk("s2_noovf", DW'(ov[1]), 0);
            end
            if (i == 8) chk("s2_ovf", DW'(ov[1]), 1);
        end
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
        chk("s2_n", nlog[1], 8);
        for (int i = 0; i < 8; i++) chk($sformatf("s2_o%0d", i), mlog[1][i], DW'(32'h10 + i));
        chk("s2_n4", nlog[0], 3);
        chk("s2_d4_last", mlog[0][2], 32'h18);

        // Push into full FIFO with simultaneous pop
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 8; i++) cyc(1, DW'(32'h20 + i), 0, 0);
        cyc(1, 32'h28, 1, 0);
        chk("s3_lvl", DW'(lvl[1]), 8);
        chk("s3_ovf", DW'(ov[1]), 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
        chk("s3_n", nlog[1], 9);
        chk("s3_last", mlog[1][8], 32'h28);

        // Gapped valid: kept are the 1st and 5th valid samples
        cyc(0, 0, 0, 1);
        for (int i = 1; i <= 8; i++) begin
            cyc(1, DW'(i), 1, 0);
            cyc(0, 0, 1, 0);
        end
        cyc(0, 0, 1, 0);
        chk("s4_n", nlog[0], 2);
        chk("s4_o0", mlog[0][0], 1);
        chk("s4_o1", mlog[0][1], 5);

        // Asynchronous reset mid-stream with level=3 and ovf=1
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 9; i++) cyc(1, DW'(32'h30 + i), 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0);
        chk("s5_pre_lvl", DW'(lvl[1]), 3);
        chk("s5_pre_ovf", DW'(ov[1]), 1);
        rst = 1'b0;
        #1;
        chk("s5_lvl", DW'(lvl[1]), 0);
        chk("s5_vld", DW'(yv[1]), 0);
        chk("s5_ovf", DW'(ov[1]), 0);
        chk("s5_dat", y_dat[1], 0);
        cyc(0, 0, 0, 0);
        rst = 1'b1;
        cyc(1, 32'h55, 1, 0);
        chk("s5_next_d1", y_dat[1], 32'h55);
        chk("s5_next_d4", y_dat[0], 32'h55);
        cyc(0, 0, 1, 0);

        // Flush with level=5 and phase=2 on the DECIM=4 instance
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 18; i++) cyc(1, DW'(32'h60 + i), 0, 0);
        chk("s6_pre_lvl", DW'(lvl[0]), 5);
        cyc(1, 32'hAA, 1, 1);
        chk("s6_lvl4", DW'(lvl[0]), 0);
        chk("s6_lvl1", DW'(lvl[1]), 0);
        chk("s6_ovf1", DW'(ov[1]), 0);
        cyc(1, 32'hBB, 1, 0);
        chk("s6_vld", DW'(yv[0]), 1);
        chk("s6_dat", y_dat[0], 32'hBB);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
